// File: rtl/inv_sub_bytes_seq.sv
// InvSubBytes over a full 128-bit state, sequenced one byte per cycle through a shared inverse S-box ROM.
// Optional feature macro: INV_SUB_BYTES_ABORT_EN adds an abort input that cancels a job in flight.
module inv_sub_bytes_seq #(
   parameter int NUM_BYTES = 16,
   parameter int ROM_LAT   = 1
) (
   input  logic                   CLK,
   input  logic                   RST_N,
   input  logic                   start,
   input  logic [8*NUM_BYTES-1:0] state_in,
`ifdef INV_SUB_BYTES_ABORT_EN
   input  logic                   abort,
`endif
   output logic                   ready,
   output logic                   done,
   output logic [8*NUM_BYTES-1:0] state_out,
   output logic                   rom_en,
   output logic [7:0]             rom_addr,
   input  logic [7:0]             rom_data
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

   // Byte i of the state lives at packed index LAST-i, so byte 0 is the MSB byte.
   localparam logic [3:0] LAST = 4'(NUM_BYTES - 1);

   state_t                    state_q, state_d;
   logic [NUM_BYTES-1:0][7:0] in_buf_q, in_buf_d;
   logic [NUM_BYTES-1:0][7:0] result_q, result_d;
   logic [NUM_BYTES-1:0][7:0] state_out_q, state_out_d;
   logic [3:0]                issue_cnt_q, issue_cnt_d;
   logic [3:0]                cap_cnt_q, cap_cnt_d;
   logic [ROM_LAT-1:0]        vld_q, vld_d;
   logic                      ready_q, ready_d;
   logic                      done_q, done_d;
   logic                      rom_en_q, rom_en_d;
   logic [7:0]                rom_addr_q, rom_addr_d;
   logic                      capture;
   logic [3:0]                issue_nxt;

   // The valid pipe alone decides when rom_data is real, so a disabled ROM's zeros are never taken.
   always_comb begin
      capture     = vld_q[ROM_LAT-1];
      issue_nxt   = issue_cnt_q + 4'd1;
      state_d     = state_q;
      in_buf_d    = in_buf_q;
      result_d    = result_q;
      state_out_d = state_out_q;
      issue_cnt_d = issue_cnt_q;
      cap_cnt_d   = cap_cnt_q;
      vld_d       = (vld_q << 1) | ROM_LAT'(rom_en_q);
      ready_d     = ready_q;
      done_d      = 1'b0;
      rom_en_d    = rom_en_q;
      rom_addr_d  = rom_addr_q;

      if (capture) begin
         result_d[LAST - cap_cnt_q] = rom_data;
         cap_cnt_d                  = cap_cnt_q + 4'd1;
      end

      case (state_q)
         S_IDLE: begin
            if (start) begin
               in_buf_d    = state_in;
               issue_cnt_d = 4'd0;
               cap_cnt_d   = 4'd0;
               rom_en_d    = 1'b1;
               rom_addr_d  = state_in[8*NUM_BYTES-1 -: 8];
               ready_d     = 1'b0;
               state_d     = S_ISSUE;
            end
         end
         S_ISSUE: begin
            issue_cnt_d = issue_nxt;
            if (issue_cnt_q == LAST) begin
               rom_en_d = 1'b0;
               state_d  = S_DRAIN;
            end else begin
               rom_addr_d = in_buf_q[LAST - issue_nxt];
            end
         end
         S_DRAIN: begin
            // The last byte lands on this same edge, so publish the merged result.
            if (capture && cap_cnt_q == LAST) begin
               state_out_d = result_d;
               done_d      = 1'b1;
               state_d     = S_DONE;
            end
         end
         S_DONE: begin
            ready_d = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

`ifdef INV_SUB_BYTES_ABORT_EN
      if (abort && (state_q == S_ISSUE || state_q == S_DRAIN)) begin
         state_d     = S_IDLE;
         state_out_d = state_out_q;
         issue_cnt_d = 4'd0;
         cap_cnt_d   = 4'd0;
         vld_d       = '0;
         rom_en_d    = 1'b0;
         ready_d     = 1'b1;
         done_d      = 1'b0;
      end
`endif
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state_q     <= S_IDLE;
         in_buf_q    <= '0;
         result_q    <= '0;
         state_out_q <= '0;
         issue_cnt_q <= 4'd0;
         cap_cnt_q   <= 4'd0;
         vld_q       <= '0;
         ready_q     <= 1'b1;
         done_q      <= 1'b0;
         rom_en_q    <= 1'b0;
         rom_addr_q  <= 8'h00;
      end else begin
         state_q     <= state_d;
         in_buf_q    <= in_buf_d;
         result_q    <= result_d;
         state_out_q <= state_out_d;
         issue_cnt_q <= issue_cnt_d;
         cap_cnt_q   <= cap_cnt_d;
         vld_q       <= vld_d;
         ready_q     <= ready_d;
         done_q      <= done_d;
         rom_en_q    <= rom_en_d;
         rom_addr_q  <= rom_addr_d;
      end
   end

   assign ready     = ready_q;
   assign done      = done_q;
   assign state_out = state_out_q;
   assign rom_en    = rom_en_q;
   assign rom_addr  = rom_addr_q;

endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// Bench for inv_sub_bytes_seq: one ROM_LAT=1 and one ROM_LAT=2 instance run the same jobs side by side.
// The inverse S-box is derived from GF(2^8) arithmetic; abort checks are built when INV_SUB_BYTES_ABORT_EN is defined.
module tb_inv_sub_bytes_seq;

   logic         CLK = 1'b0;
   logic         RST_N;
   logic         start;
   logic [127:0] state_in;
`ifdef INV_SUB_BYTES_ABORT_EN
   logic         abort;
`endif

   logic         ready1, done1, rom_en1;
   logic [7:0]   rom_addr1;
   logic [7:0]   rom_data1 = 8'h00;
   logic [127:0] state_out1;
   logic         ready2, done2, rom_en2;
   logic [7:0]   rom_addr2;
   logic [7:0]   rom_raw2  = 8'h00;
   logic [7:0]   rom_data2 = 8'h00;
   logic [127:0] state_out2;

   int           cyc   = 0;
   int           n_vec = 0;
   int           n_bad = 0;
   logic [7:0]   inv_tab [256];

   typedef struct {
      logic [127:0] din;
      logic [127:0] dexp;
   } vec_t;
   vec_t vecs [3];

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   inv_sub_bytes_seq #(.NUM_BYTES(16), .ROM_LAT(1)) dut1 (
      .CLK(CLK), .RST_N(RST_N), .start(start), .state_in(state_in),
`ifdef INV_SUB_BYTES_ABORT_EN
      .abort(abort),
`endif
      .ready(ready1), .done(done1), .state_out(state_out1),
      .rom_en(rom_en1), .rom_addr(rom_addr1), .rom_data(rom_data1)
   );

   inv_sub_bytes_seq #(.NUM_BYTES(16), .ROM_LAT(2)) dut2 (
      .CLK(CLK), .RST_N(RST_N), .start(start), .state_in(state_in),
`ifdef INV_SUB_BYTES_ABORT_EN
      .abort(abort),
`endif
      .ready(ready2), .done(done2), .state_out(state_out2),
      .rom_en(rom_en2), .rom_addr(rom_addr2), .rom_data(rom_data2)
   );

   // ROM models: registered read, zero when disabled; the second one has an extra output register.
   always @(posedge CLK) rom_data1 <= rom_en1 ? inv_tab[rom_addr1] : 8'h00;
   always @(posedge CLK) begin
      rom_raw2  <= rom_en2 ? inv_tab[rom_addr2] : 8'h00;
      rom_data2 <= rom_raw2;
   end

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      end
      return p;
   endfunction

   function automatic logic [7:0] ginv(input logic [7:0] x);
      if (x == 8'h00) return 8'h00;
      for (int c = 1; c < 256; c++)
         if (gmul(x, 8'(c)) == 8'h01) return 8'(c);
      return 8'h00;
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
      return (x << n) | (x >> (8 - n));
   endfunction

   function automatic logic [127:0] ref_model(input logic [127:0] s);
      logic [127:0] r;
      r = '0;
      for (int i = 0; i < 16; i++) r[127-8*i -: 8] = inv_tab[s[127-8*i -: 8]];
      return r;
   endfunction

   task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] want);
      n_vec++;
      if (act !== want) begin
         n_bad++;
         $display("[TB] FAIL %s: got %0h, want %0h", name, act, want);
      end
   endtask

   task automatic checkIdle(input string tag, input logic [127:0] so_want);
      checkOutput({tag, " ready1"}, 128'(ready1), 128'(1));
      checkOutput({tag, " ready2"}, 128'(ready2), 128'(1));
      checkOutput({tag, " rom_en1"}, 128'(rom_en1), 128'(0));
      checkOutput({tag, " rom_en2"}, 128'(rom_en2), 128'(0));
      checkOutput({tag, " done1"}, 128'(done1), 128'(0));
      checkOutput({tag, " done2"}, 128'(done2), 128'(0));
      checkOutput({tag, " state_out1"}, state_out1, so_want);
      checkOutput({tag, " state_out2"}, state_out2, so_want);
   endtask

   task automatic watchNoDone(input string tag, input int cycles);
      int n_d;
      n_d = 0;
      repeat (cycles) begin
         @(negedge CLK);
         if (done1 || done2) n_d++;
      end
      checkOutput({tag, " spurious done"}, 128'(n_d), 128'(0));
   endtask

   // One job on both instances: issue sequence, done timing, pulse width, result and hold.
   task automatic applyStimulus(input string tag, input logic [127:0] v, input logic [127:0] want);
      int           s, kk, d1, d2, n_d1, n_d2, bad1, bad2;
      logic [127:0] o1, o2;
      logic         en_want;
      logic [7:0]   addr_want;
      d1 = -1; d2 = -1; n_d1 = 0; n_d2 = 0; bad1 = 0; bad2 = 0;
      o1 = '0; o2 = '0;
      @(negedge CLK);
      checkOutput({tag, " ready before start"}, 128'(ready1 & ready2), 128'(1));
      start    = 1'b1;
      state_in = v;
      @(negedge CLK);
      start = 1'b0;
      s     = cyc;
      for (int k = 0; k < 24; k++) begin
         if (k > 0) @(negedge CLK);
         kk        = (k > 15) ? 15 : k;
         en_want   = (k < 16);
         addr_want = v[127-8*kk -: 8];
         if (rom_en1 !== en_want) bad1++;
         if (rom_en2 !== en_want) bad2++;
         if (k < 17 && rom_addr1 !== addr_want) bad1++;
         if (k < 17 && rom_addr2 !== addr_want) bad2++;
         if (done1) begin n_d1++; d1 = cyc - s; o1 = state_out1; end
         if (done2) begin n_d2++; d2 = cyc - s; o2 = state_out2; end
      end
      checkOutput({tag, " issue seq1"}, 128'(bad1), 128'(0));
      checkOutput({tag, " issue seq2"}, 128'(bad2), 128'(0));
      checkOutput({tag, " done1 offset"}, 128'(d1), 128'(17));
      checkOutput({tag, " done2 offset"}, 128'(d2), 128'(18));
      checkOutput({tag, " done1 width"}, 128'(n_d1), 128'(1));
      checkOutput({tag, " done2 width"}, 128'(n_d2), 128'(1));
      checkOutput({tag, " result1"}, o1, want);
      checkOutput({tag, " result2"}, o2, want);
      checkOutput({tag, " hold1"}, state_out1, want);
      checkOutput({tag, " hold2"}, state_out2, want);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, want $finish");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int           s, n1, n2;
      int           d1k [2];
      int           d2k [2];
      logic [127:0] d1v [2];
      logic [127:0] d2v [2];
      logic [127:0] v;

      for (int i = 0; i < 256; i++)
         inv_tab[i] = ginv(rotl(8'(i), 1) ^ rotl(8'(i), 3) ^ rotl(8'(i), 6) ^ 8'h05);

      vecs[0].din  = 128'h0;
      vecs[0].dexp = 128'h52525252525252525252525252525252;
      vecs[1].din  = 128'h000102030405060708090A0B0C0D0E0F;
      vecs[1].dexp = 128'h52096AD53036A538BF40A39E81F3D7FB;
      vecs[2].din  = 128'h637C00000000000000000000000000FF;
      vecs[2].dexp = 128'h0001_52525252_52525252_52525252_52_7D;

      RST_N    = 1'b0;
      start    = 1'b0;
      state_in = '0;
`ifdef INV_SUB_BYTES_ABORT_EN
      abort    = 1'b0;
`endif
      repeat (2) @(negedge CLK);
      checkIdle("reset", 128'h0);
      checkOutput("reset rom_addr1", 128'(rom_addr1), 128'(0));
      RST_N = 1'b1;

      for (int i = 0; i < 3; i++) applyStimulus($sformatf("vec%0d", i), vecs[i].din, vecs[i].dexp);

      for (int i = 0; i < 8; i++) begin
         v = {$urandom(), $urandom(), $urandom(), $urandom()};
         applyStimulus($sformatf("rand%0d", i), v, ref_model(v));
      end

      // start held high with a new value through the job: second job only after ready returns.
      n1 = 0; n2 = 0;
      d1k[0] = -1; d1k[1] = -1; d2k[0] = -1; d2k[1] = -1;
      d1v[0] = '0; d1v[1] = '0; d2v[0] = '0; d2v[1] = '0;
      @(negedge CLK);
      start    = 1'b1;
      state_in = vecs[2].din;
      @(negedge CLK);
      s        = cyc;
      state_in = vecs[1].din;
      for (int k = 0; k < 46; k++) begin
         if (k > 0) @(negedge CLK);
         if (k == 20) start = 1'b0;
         if (k == 17) checkOutput("hold ready low in done", 128'(ready1), 128'(0));
         if (k == 18) checkOutput("hold ready after done", 128'(ready1), 128'(1));
         if (done1) begin
            if (n1 < 2) begin d1k[n1] = cyc - s; d1v[n1] = state_out1; end
            n1++;
         end
         if (done2) begin
            if (n2 < 2) begin d2k[n2] = cyc - s; d2v[n2] = state_out2; end
            n2++;
         end
      end
      checkOutput("hold done1 count", 128'(n1), 128'(2));
      checkOutput("hold done2 count", 128'(n2), 128'(2));
      checkOutput("hold job1 offset1", 128'(d1k[0]), 128'(17));
      checkOutput("hold job2 offset1", 128'(d1k[1]), 128'(36));
      checkOutput("hold job1 offset2", 128'(d2k[0]), 128'(18));
      checkOutput("hold job2 offset2", 128'(d2k[1]), 128'(38));
      checkOutput("hold job1 result1", d1v[0], vecs[2].dexp);
      checkOutput("hold job2 result1", d1v[1], ref_model(vecs[1].din));
      checkOutput("hold job1 result2", d2v[0], vecs[2].dexp);
      checkOutput("hold job2 result2", d2v[1], ref_model(vecs[1].din));

      // Reset in the middle of issue: partial job is dropped and never signalled.
      @(negedge CLK);
      start    = 1'b1;
      state_in = vecs[1].din;
      @(negedge CLK);
      start = 1'b0;
      repeat (5) @(negedge CLK);
      RST_N = 1'b0;
      repeat (2) @(negedge CLK);
      RST_N = 1'b1;
      checkIdle("midreset", 128'h0);
      watchNoDone("midreset", 30);
      applyStimulus("after reset", vecs[2].din, vecs[2].dexp);

`ifdef INV_SUB_BYTES_ABORT_EN
      @(negedge CLK);
      start    = 1'b1;
      state_in = vecs[1].din;
      @(negedge CLK);
      start = 1'b0;
      repeat (8) @(negedge CLK);
      abort = 1'b1;
      @(negedge CLK);
      abort = 1'b0;
      checkIdle("abort", vecs[2].dexp);
      watchNoDone("abort", 30);
      checkOutput("abort keep1", state_out1, vecs[2].dexp);
      applyStimulus("after abort", vecs[1].din, vecs[1].dexp);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/inv_sub_bytes_seq.md
Name: inv_sub_bytes_seq

Overview:
Sequencer that performs a full 128-bit InvSubBytes using one shared single-port inverse S-box ROM. The ROM has one-cycle registered read, Read_Enable, and outputs 8'h00 when disabled. The block accepts a 16-byte state on a start/ready handshake and streams one byte address into the ROM per cycle. It collects the pipelined read data and returns the substituted state with a one-cycle done pulse. It sits between the decryption round controller and the inverse S-box ROM instance.

Parameters:
NUM_BYTES, 16, bytes per state; fixed at 16 for AES-128.
ROM_LAT, 1, ROM read latency in cycles; legal values 1 or 2. Use 2 when an output register is inserted after the ROM.

Ports:
CLK  in  1  single clock; all logic on posedge.
RST_N  in  1  reset, synchronous and active-low.
start  in  1  request; sampled only while ready=1.
state_in  in  128  input state; byte i = state_in[127-8i -: 8] (byte 0 = MSB).
ready  out  1  high in IDLE only.
done  out  1  one-cycle pulse; state_out valid from this cycle.
state_out  out  128  substituted state, same byte order; holds until the next done.
rom_en  out  1  drives ROM Read_Enable.
rom_addr  out  8  drives ROM Read_Address.
rom_data  in  8  ROM Read_Data.

Behaviour:
- Reset (RST_N=0 at a posedge): state to IDLE, ready=1, done=0, rom_en=0, rom_addr=0, state_out=0, counters=0. Reset takes effect mid-operation; a partial result is discarded and never signalled.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE: if start=1 at posedge T, latch state_in into the input buffer, clear issue_cnt and capture_cnt, and go to ISSUE. start while not in IDLE is ignored; no queuing.
- ISSUE (cycles T+1..T+16):
  - rom_en=1, rom_addr = buffered byte issue_cnt; issue_cnt increments each cycle.
  - After issue_cnt=15, go to DRAIN.
- Capture:
  - A byte issued in cycle c appears on rom_data in cycle c+ROM_LAT and is written into result byte capture_cnt at the end of that cycle.
  - Capture is driven by a ROM_LAT-deep valid shift register fed by rom_en, never by FSM state.
  - capture_cnt wraps 15 to 0 only at job end.
- DRAIN: rom_en=0, rom_addr holds its last value. Remain until capture_cnt has recorded byte 15, then go to DONE.
- DONE: state_out takes the full result and done=1 for exactly one cycle, then IDLE.
  - The done cycle is T+17+ROM_LAT (T+18 when ROM_LAT=1).
  - ready returns to 1 the cycle after done.
  - Back-to-back jobs therefore have a period of 18+ROM_LAT cycles.
- rom_en is 0 in every state except ISSUE. The ROM's 8'h00 output when disabled must never be captured.
- state_out changes only in DONE or on reset.
- Counter widths: 4 bits, no overflow beyond 15.

Optional Feature:
Macro INV_SUB_BYTES_ABORT_EN.
- Defined: adds input port abort (1 bit).
  - abort=1 at a posedge in ISSUE or DRAIN: go to IDLE next cycle, rom_en=0 immediately in that next cycle, counters cleared.
  - Any in-flight ROM data is dropped, no done pulse, state_out unchanged.
  - abort in IDLE or DONE has no effect; DONE completes normally.
  - abort and start together in IDLE: start wins.
- Not defined: no abort port, behaviour as above only.

Test Plan:
1. Reset with RST_N=0 for 2 cycles, mid-job at ISSUE cycle 5 -> next cycle ready=1, rom_en=0, done=0, state_out=0; no done pulse appears later.
2. start with state_in=128'h0 -> 16 rom_en cycles with rom_addr=8'h00 -> done at T+18, state_out=128'h52525252525252525252525252525252.
3. start with state_in=128'h000102030405060708090A0B0C0D0E0F -> rom_addr sequence 00..0F in cycles T+1..T+16, state_out=128'h52096AD53036A538BF40A39E81F3D7FB, done pulse width 1.
4. Job with state_in=128'h637C...FF (byte 0=63, byte 1=7C, byte 15=FF, others 00) -> bytes 0/1/15 = 00/01/7D, others 52. Hold start high with a new value during the job -> ignored; second job begins only after ready=1, done period 19 cycles.
5. ROM_LAT=2 with a pipeline register on rom_data, vector of scenario 3 -> same state_out, done at T+19.
6. INV_SUB_BYTES_ABORT_EN defined: abort at ISSUE cycle 8 -> rom_en low the next cycle, ready=1, no done, state_out keeps its previous value. A following start completes correctly.
